// File: rtl/uart_pkg.sv
// uart_pkg: FSM state encoding and status-word bit positions shared by the UART ports.
package uart_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uartState_t;
  localparam int BUSY_BIT = 0;
  localparam int OVR_BIT  = 1;
endpackage

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter, wraps after CLKS_PER_BIT cycles and restarts on clear.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic bitDone
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] count;
  assign bitDone = count == LAST;
  always_ff @(posedge clk) begin
    if (reset || clear || bitDone) count <= '0;
    else count <= count + 1'b1;
  end
endmodule

// File: rtl/uart_tx_port.sv
// uart_tx_port: 8N1 transmitter for the UART_TX I/O slot, status {overrun, busy} on out.
module uart_tx_port
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] in,
  output logic [15:0] out,
  output logic        tx
);
  uartState_t state, nextState;
  logic [7:0] shift, nextShift;
  logic [2:0] bitIdx, nextIdx;
  logic       overrun, nextOvr, busy, txNext, bitDone;
  logic       unusedHigh;
  assign unusedHigh = ^in[15:8];
  // Counter restarts whenever the FSM moves, so every state lasts a full bit period.
  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) baudCnt (
    .clk(clk),
    .reset(reset),
    .clear(nextState != state),
    .bitDone(bitDone)
  );
  always_comb begin
    nextState = state;
    nextShift = shift;
    nextIdx   = bitIdx;
    nextOvr   = overrun;
    unique case (state)
      IDLE: if (load) begin
        nextShift = in[7:0];
        nextOvr   = 1'b0;
        nextState = START;
      end
      START: if (bitDone) begin
        nextState = DATA;
        nextIdx   = 3'd0;
      end
      DATA: if (bitDone) begin
        nextShift = shift >> 1;
        nextIdx   = bitIdx + 3'd1;
        nextState = bitIdx == 3'd7 ? STOP : DATA;
      end
      STOP: if (bitDone) nextState = IDLE;
    endcase
    if (state != IDLE && load) nextOvr = 1'b1;
    txNext = nextState == START ? 1'b0 : nextState == DATA ? nextShift[0] : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      shift   <= '0;
      bitIdx  <= '0;
      overrun <= 1'b0;
      busy    <= 1'b0;
      tx      <= 1'b1;
    end else begin
      state   <= nextState;
      shift   <= nextShift;
      bitIdx  <= nextIdx;
      overrun <= nextOvr;
      busy    <= nextState != IDLE;
      tx      <= txNext;
    end
  end
  always_comb begin
    out           = '0;
    out[BUSY_BIT] = busy;
    out[OVR_BIT]  = overrun;
  end
endmodule

// File: tb/tb_uart_tx_port.sv
// tb_uart_tx_port: directed checks of framing, status, overrun and reset behaviour at CLKS_PER_BIT=4.
module tb_uart_tx_port;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] din = '0;
  logic [15:0] dout;
  logic        tx;
  int          errors = 0;
  int          checks = 0;

  uart_tx_port #(.CLKS_PER_BIT(4)) dut (
    .clk(clk),
    .reset(reset),
    .load(load),
    .in(din),
    .out(dout),
    .tx(tx)
  );

  always #5 clk = ~clk;

  // Called at a negedge; returns at the negedge of the first start-bit cycle.
  task automatic sendByte(input logic [15:0] d);
    load = 1'b1;
    din  = d;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Records 40 cycles of a frame (bits[0] = start bit), optionally pulsing load at cycle injectAt.
  task automatic grab(input int injectAt, input logic [15:0] injectData,
                      output logic [9:0] bits, output int glitches,
                      output int busyCycles, output logic [15:0] lastOut);
    bits = '0;
    glitches = 0;
    busyCycles = 0;
    lastOut = '0;
    for (int i = 0; i < 40; i++) begin
      if (i % 4 == 0) bits[i/4] = tx;
      else if (tx !== bits[i/4]) glitches++;
      if (dout[0] === 1'b1) busyCycles++;
      lastOut = dout;
      load = (i == injectAt);
      if (i == injectAt) din = injectData;
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (tx !== 1'b1 || dout !== 16'h0000) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: tx=%b out=%h, need tx=1 out=0000", i, tx, dout);
      end
      @(negedge clk);
    end
    reset = 1'b1;
    load = 1'b1;
    din = 16'h00AA;
    @(negedge clk);
    reset = 1'b0;
    load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (tx !== 1'b1 || dout !== 16'h0000) begin
        errors++;
        $display("FAIL reset_and_load cycle %0d: tx=%b out=%h, need tx=1 out=0000", i, tx, dout);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_frame;
    logic [9:0] bits;
    int g, b;
    logic [15:0] lo;
    sendByte(16'h00A5);
    grab(-1, 16'h0, bits, g, b, lo);
    checks++;
    if (bits !== 10'b1_1010_0101_0) begin
      errors++;
      $display("FAIL frame_a5_bits: got %b, need %b", bits, 10'b1_1010_0101_0);
    end
    checks++;
    if (g !== 0) begin
      errors++;
      $display("FAIL frame_a5_stable: %0d mid-bit changes, need 0", g);
    end
    checks++;
    if (b !== 40 || lo !== 16'h0001) begin
      errors++;
      $display("FAIL frame_a5_busy: busy cycles=%0d last=%h, need 40 and 0001", b, lo);
    end
    checks++;
    if (dout !== 16'h0000 || tx !== 1'b1) begin
      errors++;
      $display("FAIL frame_a5_end: out=%h tx=%b, need 0000 and 1", dout, tx);
    end
  endtask

  task automatic test_overrun;
    logic [9:0] bits;
    int g, b;
    logic [15:0] lo;
    sendByte(16'h0041);
    grab(10, 16'h0042, bits, g, b, lo);
    checks++;
    if (bits !== {1'b1, 8'h41, 1'b0} || g !== 0) begin
      errors++;
      $display("FAIL overrun_frame: got %b glitches=%0d, need %b", bits, g, {1'b1, 8'h41, 1'b0});
    end
    checks++;
    if (lo !== 16'h0003) begin
      errors++;
      $display("FAIL overrun_status_busy: got %h, need 0003", lo);
    end
    checks++;
    if (dout !== 16'h0002 || tx !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: out=%h tx=%b, need 0002 and 1", dout, tx);
    end
    sendByte(16'h0043);
    checks++;
    if (dout !== 16'h0001 || tx !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: out=%h tx=%b, need 0001 and 0", dout, tx);
    end
    grab(39, 16'h0099, bits, g, b, lo);
    checks++;
    if (bits !== {1'b1, 8'h43, 1'b0} || lo !== 16'h0001) begin
      errors++;
      $display("FAIL last_stop_frame: got %b last=%h, need %b and 0001", bits, lo, {1'b1, 8'h43, 1'b0});
    end
    checks++;
    if (dout !== 16'h0002 || tx !== 1'b1) begin
      errors++;
      $display("FAIL last_stop_drop: out=%h tx=%b, need 0002 and 1", dout, tx);
    end
    @(negedge clk);
    checks++;
    if (dout !== 16'h0002 || tx !== 1'b1) begin
      errors++;
      $display("FAIL last_stop_no_start: out=%h tx=%b, need 0002 and 1", dout, tx);
    end
  endtask

  task automatic test_high_byte;
    logic [9:0] bits;
    int g, b;
    logic [15:0] lo;
    sendByte(16'hFF55);
    checks++;
    if (dout !== 16'h0001) begin
      errors++;
      $display("FAIL high_byte_status: got %h, need 0001", dout);
    end
    grab(-1, 16'h0, bits, g, b, lo);
    checks++;
    if (bits !== 10'b1_0101_0101_0 || g !== 0 || b !== 40) begin
      errors++;
      $display("FAIL high_byte_frame: got %b glitches=%0d busy=%0d, need %b 0 40", bits, g, b, 10'b1_0101_0101_0);
    end
  endtask

  task automatic test_reset_mid;
    logic [9:0] bits;
    int g, b;
    logic [15:0] lo;
    sendByte(16'h00FF);
    repeat (15) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || dout !== 16'h0001) begin
      errors++;
      $display("FAIL mid_frame_pre: tx=%b out=%h, need 1 and 0001", tx, dout);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (tx !== 1'b1 || dout !== 16'h0000) begin
        errors++;
        $display("FAIL mid_frame_abort cycle %0d: tx=%b out=%h, need 1 and 0000", i, tx, dout);
      end
      @(negedge clk);
    end
    sendByte(16'h0001);
    grab(-1, 16'h0, bits, g, b, lo);
    checks++;
    if (bits !== 10'b1_0000_0001_0 || g !== 0 || b !== 40) begin
      errors++;
      $display("FAIL after_reset_frame: got %b glitches=%0d busy=%0d, need %b 0 40", bits, g, b, 10'b1_0000_0001_0);
    end
    checks++;
    if (dout !== 16'h0000 || tx !== 1'b1) begin
      errors++;
      $display("FAIL after_reset_end: out=%h tx=%b, need 0000 and 1", dout, tx);
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] bits;
    int g, b;
    logic [15:0] lo;
    sendByte(16'h0012);
    grab(-1, 16'h0, bits, g, b, lo);
    checks++;
    if (bits !== 10'b1_0001_0010_0 || g !== 0 || b !== 40) begin
      errors++;
      $display("FAIL b2b_first: got %b glitches=%0d busy=%0d, need %b 0 40", bits, g, b, 10'b1_0001_0010_0);
    end
    checks++;
    if (dout !== 16'h0000 || tx !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap: out=%h tx=%b, need 0000 and 1", dout, tx);
    end
    sendByte(16'h0034);
    grab(-1, 16'h0, bits, g, b, lo);
    checks++;
    if (bits !== 10'b1_0011_0100_0 || g !== 0 || b !== 40) begin
      errors++;
      $display("FAIL b2b_second: got %b glitches=%0d busy=%0d, need %b 0 40", bits, g, b, 10'b1_0011_0100_0);
    end
    checks++;
    if (dout !== 16'h0000 || tx !== 1'b1) begin
      errors++;
      $display("FAIL b2b_end: out=%h tx=%b, need 0000 and 1", dout, tx);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_frame;
    test_overrun;
    test_high_byte;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
